multicycle_control_fsm: RTL and testbench

Moore-style controller that sequences a shared multi-cycle MIPS datapath: one memory, one ALU, one register file. It supports the same instruction set as the single-cycle controller: add, sub, and, or, slt, addi, beq, lw, sw, j. It also handles variable-latency memory through a ready handshake. It sits between the instruction register (Op/Funct fields) and the datapath muxes and enables.

---
 rtl/multicycle_control_fsm_if.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Bundle of the signals between the multi-cycle controller and the datapath.
// The master side is the controller; the slave side is the datapath and IR.
interface multicycle_control_fsm_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       InstrDone;
    logic       Error;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegDst, MemtoReg, RegWrite, InstrDone, Error, State
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegDst, MemtoReg, RegWrite, InstrDone, Error, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore controller for a shared multi-cycle MIPS datapath (add/sub/and/or/slt,
// addi, beq, lw, sw, j) with a MemReady handshake for variable-latency memory.
module multicycle_control_fsm #(
    parameter logic [2:0] ALU_AND = 3'b000,
    parameter logic [2:0] ALU_OR  = 3'b001,
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110,
    parameter logic [2:0] ALU_SLT = 3'b111
) (
    input  logic                        CLK,
    input  logic                        RST,
    multicycle_control_fsm_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        ERR    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Held as a raw 4-bit vector so the unused codes 13..15 stay representable.
    logic [3:0] state_q, state_d;

    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       pcwrite, branch;
    logic       irwrite, memwrite, regwrite, instrdone;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        unique case (bus.Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        memwrite       = 1'b0;
        irwrite        = 1'b0;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        regwrite       = 1'b0;
        instrdone      = 1'b0;

        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.MemReady) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.Op)
                    OP_RTYPE:     state_d = funct_ok ? EXEC : ERR;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = ERR;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.Op == OP_LW)      state_d = MEMRD;
                else if (bus.Op == OP_SW) state_d = MEMWR;
                else                      state_d = ERR;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                regwrite     = 1'b1;
                instrdone    = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                bus.IorD = 1'b1;
                memwrite = 1'b1;
                if (bus.MemReady) begin
                    instrdone = 1'b1;
                    state_d   = FETCH;
                end
            end
            EXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu;
                state_d        = ALUWB;
            end
            ALUWB: begin
                bus.RegDst = 1'b1;
                regwrite   = 1'b1;
                instrdone  = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_SUB;
                branch         = 1'b1;
                bus.PCSrc      = 2'b01;
                instrdone      = 1'b1;
                state_d        = FETCH;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                regwrite  = 1'b1;
                instrdone = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                bus.PCSrc = 2'b10;
                pcwrite   = 1'b1;
                instrdone = 1'b1;
                state_d   = FETCH;
            end
            ERR:     state_d = ERR;
            default: state_d = FETCH;
        endcase
    end

    // Enables are suppressed while RST is high so an in-flight access cannot commit.
    always_comb begin
        bus.IRWrite   = irwrite   & ~RST;
        bus.MemWrite  = memwrite  & ~RST;
        bus.RegWrite  = regwrite  & ~RST;
        bus.InstrDone = instrdone & ~RST;
        bus.PCEn      = (pcwrite | (branch & bus.Zero)) & ~RST;
        bus.Error     = (state_q == ERR);
        bus.State     = state_q;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and checks state sequence and decoded controls.
module tb_multicycle_control_fsm;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   passed = 0;

    always #5 CLK = ~CLK;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.MemReady = 1'b1; bus.Op = 6'b0; bus.Funct = 6'b0; bus.Zero = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.State !== 4'd0) $display("FAIL reset_state got=%0d exp=0", bus.State);
        else passed++;
        checks++;
        if ({bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite, bus.Error} !== 5'b0)
            $display("FAIL reset_enables got=%b exp=00000",
                     {bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite, bus.Error});
        else passed++;
        RST = 1'b0;
        #1;
        checks++;
        if ({bus.IRWrite, bus.PCEn, bus.MemRead, bus.ALUSrcB} !== 5'b11101)
            $display("FAIL fetch_decode got=%b exp=11101",
                     {bus.IRWrite, bus.PCEn, bus.MemRead, bus.ALUSrcB});
        else passed++;
        // Park in FETCH for the next test.
        bus.MemReady = 1'b0;
    endtask

    task automatic test_rtype(input logic [5:0] funct, input logic [2:0] alu, input string nm);
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        bus.Op = 6'b000000; bus.Funct = funct; bus.MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.State !== exp[i]) $display("FAIL %s_state%0d got=%0d exp=%0d", nm, i, bus.State, exp[i]);
            else passed++;
            if (i == 2) begin
                checks++;
                if ({bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB} !== {alu, 3'b100})
                    $display("FAIL %s_exec got=%b exp=%b", nm,
                             {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB}, {alu, 3'b100});
                else passed++;
            end
            if (i == 3) begin
                checks++;
                if ({bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone} !== 4'b1101)
                    $display("FAIL %s_wb got=%b exp=1101", nm,
                             {bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone});
                else passed++;
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0) $display("FAIL %s_end got=%0d exp=0", nm, bus.State);
        else passed++;
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        bus.Op = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            bus.MemReady = !(i == 3 || i == 4);
            #1;
            checks++;
            if (bus.State !== exp[i]) $display("FAIL lw_state%0d got=%0d exp=%0d", i, bus.State, exp[i]);
            else passed++;
            if (exp[i] == 4'd3) begin
                checks++;
                if ({bus.IorD, bus.MemRead, bus.RegWrite} !== 3'b110)
                    $display("FAIL lw_memrd%0d got=%b exp=110", i, {bus.IorD, bus.MemRead, bus.RegWrite});
                else passed++;
            end
            if (i == 6) begin
                checks++;
                if ({bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.InstrDone} !== 4'b1101)
                    $display("FAIL lw_memwb got=%b exp=1101",
                             {bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.InstrDone});
                else passed++;
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0) $display("FAIL lw_end got=%0d exp=0", bus.State);
        else passed++;
    endtask

    task automatic test_beq(input logic zero);
        logic [3:0] exp [3] = '{4'd0, 4'd1, 4'd8};
        bus.Op = 6'b000100; bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Zero = (i == 2) ? zero : 1'b0;
            #1;
            checks++;
            if (bus.State !== exp[i]) $display("FAIL beq%0d_state%0d got=%0d exp=%0d", zero, i, bus.State, exp[i]);
            else passed++;
            if (i == 2) begin
                checks++;
                if ({bus.PCEn, bus.PCSrc, bus.ALUControl, bus.InstrDone} !== {zero, 2'b01, 3'b110, 1'b1})
                    $display("FAIL beq%0d_branch got=%b exp=%b", zero,
                             {bus.PCEn, bus.PCSrc, bus.ALUControl, bus.InstrDone},
                             {zero, 2'b01, 3'b110, 1'b1});
                else passed++;
            end
            tick();
        end
        bus.Zero = 1'b0;
        checks++;
        if (bus.State !== 4'd0) $display("FAIL beq%0d_end got=%0d exp=0", zero, bus.State);
        else passed++;
    endtask

    task automatic test_fetch_stall_jump();
        bus.Op = 6'b000010; bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.State, bus.IRWrite, bus.PCEn, bus.MemRead} !== {4'd0, 3'b001})
                $display("FAIL stall%0d got=%b exp=0000001", i,
                         {bus.State, bus.IRWrite, bus.PCEn, bus.MemRead});
            else passed++;
            tick();
        end
        bus.MemReady = 1'b1;
        #1;
        checks++;
        if ({bus.State, bus.IRWrite, bus.PCEn} !== {4'd0, 2'b11})
            $display("FAIL stall_release got=%b exp=000011", {bus.State, bus.IRWrite, bus.PCEn});
        else passed++;
        tick();
        tick();
        checks++;
        if ({bus.State, bus.PCSrc, bus.PCEn, bus.InstrDone, bus.RegWrite} !== {4'd11, 2'b10, 3'b110})
            $display("FAIL jump got=%b exp=101110110",
                     {bus.State, bus.PCSrc, bus.PCEn, bus.InstrDone, bus.RegWrite});
        else passed++;
        tick();
        checks++;
        if (bus.State !== 4'd0) $display("FAIL jump_end got=%0d exp=0", bus.State);
        else passed++;
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] funct, input int hold);
        bus.Op = op; bus.Funct = funct; bus.MemReady = 1'b1;
        tick();
        tick();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if ({bus.State, bus.Error, bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite} !==
                {4'd12, 5'b10000})
                $display("FAIL err_%b_%b_cyc%0d got=%b exp=110010000", op, funct, i,
                         {bus.State, bus.Error, bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite});
            else passed++;
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if ({bus.State, bus.Error} !== 5'b00000)
            $display("FAIL err_recover got=%b exp=00000", {bus.State, bus.Error});
        else passed++;
    endtask

    task automatic test_sw(input logic rst_in_memwr);
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        bus.Op = 6'b101011; bus.MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) RST = rst_in_memwr;
            #1;
            checks++;
            if (bus.State !== exp[i]) $display("FAIL sw%0d_state%0d got=%0d exp=%0d", rst_in_memwr, i, bus.State, exp[i]);
            else passed++;
            if (i == 3) begin
                checks++;
                if ({bus.IorD, bus.MemWrite, bus.InstrDone} !== {1'b1, ~rst_in_memwr, ~rst_in_memwr})
                    $display("FAIL sw%0d_memwr got=%b exp=%b", rst_in_memwr,
                             {bus.IorD, bus.MemWrite, bus.InstrDone},
                             {1'b1, ~rst_in_memwr, ~rst_in_memwr});
                else passed++;
            end
            tick();
        end
        RST = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if ({bus.State, bus.MemWrite, bus.InstrDone, bus.RegWrite} !== 7'b0)
            $display("FAIL sw%0d_after got=%b exp=0000000", rst_in_memwr,
                     {bus.State, bus.MemWrite, bus.InstrDone, bus.RegWrite});
        else passed++;
    endtask

    task automatic test_addi();
        bus.Op = 6'b001000; bus.MemReady = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.State, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite} !== {4'd9, 3'b110, 3'b010, 1'b0})
            $display("FAIL addi_ex got=%b exp=10011100100",
                     {bus.State, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite});
        else passed++;
        tick();
        checks++;
        if ({bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone} !== {4'd10, 4'b1001})
            $display("FAIL addi_wb got=%b exp=10101001",
                     {bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.InstrDone});
        else passed++;
        tick();
        checks++;
        if (bus.State !== 4'd0) $display("FAIL addi_end got=%0d exp=0", bus.State);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rtype(6'b100000, 3'b010, "add");
        test_rtype(6'b100010, 3'b110, "sub");
        test_rtype(6'b100100, 3'b000, "and");
        test_rtype(6'b100101, 3'b001, "or");
        test_rtype(6'b101010, 3'b111, "slt");
        test_lw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_fetch_stall_jump();
        test_addi();
        test_sw(1'b0);
        test_illegal(6'b111111, 6'b000000, 10);
        test_illegal(6'b000000, 6'b000000, 2);
        test_sw(1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
